clk_period_meter: RTL and testbench

Measures an incoming slow clock, such as the divided clock produced elsewhere in the design, from inside the fast system clock domain. It synchronises the input and detects its rising edges. It reports the period and high time in system-clock cycles and flags lock when the period is stable. It sits at the consuming end of a divided-clock path, as a self-check and a frequency monitor.

---
 rtl/clk_meter_pkg.sv | 14 +
 rtl/sync_2ff.sv | 25 ++
 rtl/clk_period_meter.sv | 186 ++++++++++++++++++
 tb/tb_clk_period_meter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_meter_pkg.sv
// Shared state encoding and default constants for the clock period meter.
package clk_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    MEAS  = 2'd2
  } meter_state_e;

  localparam int unsigned CNT_W_DEF    = 16;
  localparam int unsigned TOL_DEF      = 1;
  localparam int unsigned LOCK_CNT_DEF = 4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, synchronous active-high reset.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // two-stage capture of the asynchronous input
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period/high time of a slow clock in system-clock cycles, with lock and timeout.
// Define CLK_METER_DUTY_EN to build the high-time counter; otherwise high_time reads 0.
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned TOL      = TOL_DEF,
  parameter int unsigned LOCK_CNT = LOCK_CNT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int unsigned      MC_W     = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] L_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]   L_TOL    = (CNT_W + 1)'(TOL);
  localparam logic [MC_W-1:0]  L_LOCK   = MC_W'(LOCK_CNT);
  localparam logic [MC_W-1:0]  L_MC_ONE = MC_W'(1);

  logic             w_s;
  logic             r_s_d;
  logic             w_edge;
  meter_state_e     r_state;
  meter_state_e     w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W:0]   w_diff_up;
  logic [CNT_W:0]   w_diff_dn;
  logic             w_match;
  logic             w_report;
  logic             w_compare;
  logic             w_sat;
  logic             w_tmo;
  logic [MC_W-1:0]  r_match_cnt;
  logic [MC_W-1:0]  w_match_inc;
  logic             r_period_valid;
  logic             r_locked;
  logic             r_timeout;

  sync_2ff u_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (clk_in),
    .o_q   (w_s)
  );

  // history flop for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_d <= 1'b0;
    end else begin
      r_s_d <= w_s;
    end
  end

  assign w_edge    = w_s & ~r_s_d;
  assign w_sat     = (r_cnt == L_MAX);
  assign w_report  = w_edge & (r_state != IDLE);
  assign w_compare = w_edge & (r_state == MEAS);
  // an edge coinciding with saturation still counts as a normal report
  assign w_tmo     = ~w_edge & w_sat & (r_state != IDLE);

  // both directions at CNT_W+1 bits: the wrong-direction result is huge and never matches
  assign w_diff_up   = {1'b0, r_cnt} - {1'b0, r_period};
  assign w_diff_dn   = {1'b0, r_period} - {1'b0, r_cnt};
  assign w_match     = (w_diff_up <= L_TOL) | (w_diff_dn <= L_TOL);
  assign w_match_inc = (r_match_cnt == L_LOCK) ? r_match_cnt : (r_match_cnt + L_MC_ONE);

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_edge) w_state_nxt = ARMED;
        else        w_state_nxt = IDLE;
      end
      ARMED: begin
        if (w_edge)     w_state_nxt = MEAS;
        else if (w_sat) w_state_nxt = IDLE;
        else            w_state_nxt = ARMED;
      end
      MEAS: begin
        if (w_edge)     w_state_nxt = MEAS;
        else if (w_sat) w_state_nxt = IDLE;
        else            w_state_nxt = MEAS;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // edge-to-edge cycle counter, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_edge) begin
      r_cnt <= L_ONE;
    end else if (!w_sat) begin
      r_cnt <= r_cnt + L_ONE;
    end
  end

  // period report and valid pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_period       <= {CNT_W{1'b0}};
      r_period_valid <= 1'b0;
    end else begin
      r_period_valid <= w_report;
      if (w_report) r_period <= r_cnt;
    end
  end

  // consecutive-match counter and lock flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_match_cnt <= {MC_W{1'b0}};
      r_locked    <= 1'b0;
    end else if (w_tmo) begin
      r_match_cnt <= {MC_W{1'b0}};
      r_locked    <= 1'b0;
    end else if (w_compare && w_match) begin
      r_match_cnt <= w_match_inc;
      r_locked    <= (w_match_inc == L_LOCK);
    end else if (w_compare) begin
      r_match_cnt <= {MC_W{1'b0}};
      r_locked    <= 1'b0;
    end
  end

  // timeout level: set on saturation, cleared by the next edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timeout <= 1'b0;
    end else if (w_tmo) begin
      r_timeout <= 1'b1;
    end else if (w_edge) begin
      r_timeout <= 1'b0;
    end
  end

`ifdef CLK_METER_DUTY_EN
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_high_time;

  // high-phase counter and its report register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hcnt      <= {CNT_W{1'b0}};
      r_high_time <= {CNT_W{1'b0}};
    end else begin
      if (w_edge) begin
        r_hcnt <= L_ONE;
      end else if (w_s && (r_hcnt != L_MAX)) begin
        r_hcnt <= r_hcnt + L_ONE;
      end
      if (w_report) r_high_time <= r_hcnt;
    end
  end

  assign high_time = r_high_time;
`else
  assign high_time = {CNT_W{1'b0}};
`endif

  assign period       = r_period;
  assign period_valid = r_period_valid;
  assign locked       = r_locked;
  assign timeout      = r_timeout;

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter: clk_in is driven one clk cycle at a time and an
// edge-timestamp model predicts every report, lock state and timeout.
module tb_clk_period_meter;

  localparam int TOL  = 1;
  localparam int LOCK = 4;
`ifdef CLK_METER_DUTY_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_in = 1'b0;
  logic [15:0] period;
  logic [15:0] high_time;
  logic        period_valid;
  logic        locked;
  logic        timeout;

  clk_period_meter dut (
    .clk          (clk),
    .rst          (rst),
    .clk_in       (clk_in),
    .period       (period),
    .high_time    (high_time),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int p;
    int h;
    bit lk;
  } rpt_t;

  rpt_t obs_q[$];
  rpt_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_rise = 0;
  int   high_cnt = 0;
  int   n_valid_rst = 0;
  bit   prev_v = 1'b0;
  bit   m_armed = 1'b0;
  bit   m_meas = 1'b0;
  int   m_prev = 0;
  int   m_matches = 0;
  int   m_last_period = 0;

  // model: a rising edge of clk_in reports the time since the previous one
  task automatic model_rise();
    int   p;
    int   d;
    rpt_t e;
    p = cyc - last_rise;
    if (m_armed) begin
      if (m_meas) begin
        d = (p > m_prev) ? p - m_prev : m_prev - p;
        if (d <= TOL) m_matches = (m_matches < LOCK) ? m_matches + 1 : LOCK;
        else          m_matches = 0;
      end
      m_meas = 1'b1;
      m_prev = p;
      m_last_period = p;
      e.p  = p;
      e.h  = DUTY ? high_cnt : 0;
      e.lk = (m_matches == LOCK);
      exp_q.push_back(e);
    end
    m_armed   = 1'b1;
    last_rise = cyc;
    high_cnt  = 0;
  endtask

  // one clk cycle: capture outputs at the falling edge, then drive the next input values
  task automatic tick(input logic v, input logic r);
    rpt_t o;
    @(negedge clk);
    if (period_valid === 1'b1) begin
      o.p  = int'(period);
      o.h  = int'(high_time);
      o.lk = locked;
      obs_q.push_back(o);
      if (rst === 1'b1) n_valid_rst++;
    end
    rst    = r;
    clk_in = v;
    cyc++;
    if (r) begin
      m_armed = 1'b0; m_meas = 1'b0; m_matches = 0; m_last_period = 0;
      prev_v = 1'b0; high_cnt = 0;
    end else begin
      if (v && !prev_v) model_rise();
      if (v) high_cnt++;
      prev_v = v;
    end
  endtask

  task automatic drive_period(input int h, input int l);
    repeat (h) tick(1'b1, 1'b0);
    repeat (l) tick(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 40; i++) tick(((i % 8) < 4), 1'b1);
    n_cmp++;
    if ({period, high_time, period_valid, locked, timeout} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got p=%0d h=%0d v=%b lk=%b to=%b, expected all 0",
               period, high_time, period_valid, locked, timeout);
    end
    n_cmp++;
    if (n_valid_rst !== 0) begin
      n_fail++;
      $display("FAIL reset_valid: got %0d period_valid pulses during reset, expected 0", n_valid_rst);
    end
    repeat (6) tick(1'b0, 1'b0);
  endtask

  task automatic test_lock();
    rpt_t o, e;
    repeat (7) drive_period(17, 17);
    n_cmp++;
    if (obs_q.size() == 0 || obs_q[0].p !== 34) begin
      n_fail++;
      $display("FAIL lock_first_period: got %0d reports (first p=%0d), expected first p=34",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0].p : -1);
    end
    n_cmp++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_level: got locked=%b, expected 1", locked);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL lock_count: got %0d reports, expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o.p !== e.p || o.h !== e.h || o.lk !== e.lk) begin
        n_fail++;
        $display("FAIL lock_report: got p=%0d h=%0d lk=%b, expected p=%0d h=%0d lk=%b",
                 o.p, o.h, o.lk, e.p, e.h, e.lk);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_step();
    rpt_t o, e;
    repeat (4) begin
      drive_period(17, 17);
      drive_period(17, 18);
    end
    repeat (6) drive_period(20, 20);
    n_cmp++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL step_relock: got locked=%b, expected 1", locked);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL step_count: got %0d reports, expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o.p !== e.p || o.h !== e.h || o.lk !== e.lk) begin
        n_fail++;
        $display("FAIL step_report: got p=%0d h=%0d lk=%b, expected p=%0d h=%0d lk=%b",
                 o.p, o.h, o.lk, e.p, e.h, e.lk);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_timeout();
    rpt_t o, e;
    tick(1'b1, 1'b0);
    for (int j = 1; j <= 65545; j++) begin
      tick(1'b1, 1'b0);
      if (j == 65536) begin
        n_cmp++;
        if (timeout !== 1'b0) begin
          n_fail++;
          $display("FAIL timeout_early: got timeout=%b before saturation, expected 0", timeout);
        end
      end
      if (j == 65540) begin
        n_cmp++;
        if (timeout !== 1'b1 || locked !== 1'b0 || int'(period) !== m_last_period) begin
          n_fail++;
          $display("FAIL timeout_set: got to=%b lk=%b p=%0d, expected to=1 lk=0 p=%0d",
                   timeout, locked, period, m_last_period);
        end
      end
    end
    m_armed = 1'b0; m_meas = 1'b0; m_matches = 0;
    repeat (20) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    n_cmp++;
    if (timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_hold: got timeout=%b before restart edge detected, expected 1", timeout);
    end
    repeat (5) tick(1'b1, 1'b0);
    n_cmp++;
    if (timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear: got timeout=%b after restart edge, expected 0", timeout);
    end
    repeat (17) tick(1'b0, 1'b0);
    repeat (3) drive_period(17, 17);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL timeout_count: got %0d reports, expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o.p !== e.p || o.h !== e.h || o.lk !== e.lk) begin
        n_fail++;
        $display("FAIL timeout_report: got p=%0d h=%0d lk=%b, expected p=%0d h=%0d lk=%b",
                 o.p, o.h, o.lk, e.p, e.h, e.lk);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    rpt_t o, e;
    int   n_before;
    repeat (6) drive_period(17, 17);
    n_cmp++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_prelock: got locked=%b, expected 1", locked);
    end
    drive_period(17, 8);
    repeat (3) tick(1'b0, 1'b1);
    n_cmp++;
    if ({period, high_time, period_valid, locked, timeout} !== 35'd0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got p=%0d h=%0d v=%b lk=%b to=%b, expected all 0",
               period, high_time, period_valid, locked, timeout);
    end
    repeat (9) tick(1'b0, 1'b0);
    n_before = obs_q.size();
    drive_period(17, 17);
    n_cmp++;
    if (obs_q.size() !== n_before) begin
      n_fail++;
      $display("FAIL rstmid_first_edge: got %0d new reports after one edge, expected 0",
               obs_q.size() - n_before);
    end
    repeat (3) drive_period(17, 17);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rstmid_count: got %0d reports, expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o.p !== e.p || o.h !== e.h || o.lk !== e.lk) begin
        n_fail++;
        $display("FAIL rstmid_report: got p=%0d h=%0d lk=%b, expected p=%0d h=%0d lk=%b",
                 o.p, o.h, o.lk, e.p, e.h, e.lk);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_duty();
    rpt_t o, e;
    // reset released with clk_in high: the spurious edge only arms the meter
    repeat (3) tick(1'b1, 1'b1);
    repeat (6) tick(1'b1, 1'b0);
    repeat (30) tick(1'b0, 1'b0);
    repeat (5) drive_period(10, 30);
    n_cmp++;
    if (period !== 16'd40 || high_time !== (DUTY ? 16'd10 : 16'd0) || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL duty_last: got p=%0d h=%0d lk=%b, expected p=40 h=%0d lk=0",
               period, high_time, locked, DUTY ? 10 : 0);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL duty_count: got %0d reports, expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o.p !== e.p || o.h !== e.h || o.lk !== e.lk) begin
        n_fail++;
        $display("FAIL duty_report: got p=%0d h=%0d lk=%b, expected p=%0d h=%0d lk=%b",
                 o.p, o.h, o.lk, e.p, e.h, e.lk);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    rpt_t o, e;
    int   bh, bl, l;
    bh = int'($urandom_range(2, 40));
    bl = int'($urandom_range(2, 40));
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        bh = int'($urandom_range(2, 40));
        bl = int'($urandom_range(2, 40));
      end
      l = bl + int'($urandom_range(0, 2)) - 1;
      if (l < 2) l = 2;
      drive_period(bh, l);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL random_count: got %0d reports, expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o.p !== e.p || o.h !== e.h || o.lk !== e.lk) begin
        n_fail++;
        $display("FAIL random_report: got p=%0d h=%0d lk=%b, expected p=%0d h=%0d lk=%b",
                 o.p, o.h, o.lk, e.p, e.h, e.lk);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_lock();
    test_step();
    test_timeout();
    test_reset_mid();
    test_duty();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
